// File: rtl/echo_train_gen.sv
// Multi-echo rangefinder stimulus: start pulse plus N_ECHO Gaussian echoes per frame,
// summed with optional LFSR noise into a saturating registered sample stream.
module echo_train_gen #(
  parameter int N_ECHO  = 5,
  parameter int DW      = 10,
  parameter int CNT_W   = 16,
  parameter int PERIOD  = 200,
  parameter int NOISE_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          mode,
  input  logic                          noise_en,
  input  logic [8*(N_ECHO+1)-1:0]       amp_i,
  input  logic [CNT_W*(N_ECHO+1)-1:0]   delay_i,
  output logic [DW-1:0]                 sum_o,
  output logic [7:0]                    start_o,
  output logic                          busy,
  output logic                          frame_o
);

  localparam int NP  = N_ECHO + 1;
  localparam int SW0 = (DW > 12) ? DW : 12;
  // 9 pulses of 254 fit in 12 bits; two guard bits cover the noise term on top.
  localparam int SW  = ((NOISE_W > SW0) ? NOISE_W : SW0) + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*NP-1:0]         amp_q, amp_d;
  logic [CNT_W*NP-1:0]     dly_q, dly_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [DW-1:0]           sum_q, sum_d;
  logic [7:0]              st_q, st_d;
  logic                    frame_q, frame_d;

  logic                    last;
  logic [7:0]              pv [NP];
  logic [SW-1:0]           acc;
  logic [SW-1:0]           noise;

  function automatic logic [7:0] shape(input logic [3:0] i);
    case (i)
      4'd0:  shape = 8'd2;
      4'd1:  shape = 8'd5;
      4'd2:  shape = 8'd14;
      4'd3:  shape = 8'd35;
      4'd4:  shape = 8'd71;
      4'd5:  shape = 8'd124;
      4'd6:  shape = 8'd185;
      4'd7:  shape = 8'd235;
      4'd8:  shape = 8'd255;
      4'd9:  shape = 8'd235;
      4'd10: shape = 8'd185;
      4'd11: shape = 8'd124;
      4'd12: shape = 8'd71;
      4'd13: shape = 8'd35;
      4'd14: shape = 8'd14;
      default: shape = 8'd5;
    endcase
  endfunction

  function automatic logic [7:0] pulse_val(input logic [7:0] a, input logic [CNT_W-1:0] d,
                                           input logic [CNT_W-1:0] c);
    logic [CNT_W:0] cw, lo, hi, off;
    logic [15:0]    prod;
    cw   = {1'b0, c};
    lo   = {1'b0, d};
    hi   = lo + (CNT_W+1)'(15);
    off  = cw - lo;
    prod = {8'd0, a} * {8'd0, shape(4'(off))};
    pulse_val = (cw >= lo && cw <= hi) ? 8'(prod >> 8) : 8'd0;
  endfunction

  assign last = (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    dly_d   = dly_q;
    frame_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          amp_d   = amp_i;
          dly_d   = delay_i;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          frame_d = 1'b1;
          cnt_d   = '0;
          if (mode) begin
            amp_d = amp_i;
            dly_d = delay_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  generate
    if (NOISE_W > 0) begin : g_noise
      assign noise = noise_en ? SW'(lfsr_q[NOISE_W-1:0]) : '0;
    end else begin : g_no_noise
      assign noise = '0;
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int k = 0; k < NP; k++) begin
      pv[k] = pulse_val(amp_q[8*k +: 8], dly_q[CNT_W*k +: CNT_W], cnt_q);
      acc   = acc + SW'(pv[k]);
    end
    acc = acc + noise;
  end

  always_comb begin
    sum_d = '0;
    st_d  = '0;
    if (state_q == RUN && !stop) begin
      sum_d = (acc > SW'((1 << DW) - 1)) ? '1 : acc[DW-1:0];
      st_d  = pv[0];
    end
  end

  // Taps 16,14,13,11 in right-shift form: feedback from bits 0,2,3,5.
  assign lfsr_d = (state_q == RUN) ?
                  {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amp_q   <= '0;
      dly_q   <= '0;
      lfsr_q  <= 16'hACE1;
      sum_q   <= '0;
      st_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_d;
      sum_q   <= sum_d;
      st_q    <= st_d;
      frame_q <= frame_d;
    end
  end

  assign sum_o   = sum_q;
  assign start_o = st_q;
  assign frame_o = frame_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_echo_train_gen.sv
// Randomized scoreboard bench for echo_train_gen with a frame-level reference model.
module tb_echo_train_gen;
  localparam int NP      = 6;
  localparam int DW      = 9;
  localparam int CNT_W   = 16;
  localparam int PERIOD  = 200;
  localparam int NOISE_W = 4;
  localparam int SMAX    = (1 << DW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, mode = 1'b0, noise_en = 1'b0;
  int   amp [NP];
  int   dly [NP];
  logic [8*NP-1:0]     amp_i;
  logic [CNT_W*NP-1:0] delay_i;
  logic [DW-1:0]       sum_o;
  logic [7:0]          start_o;
  logic                busy, frame_o;

  int def_amp [NP] = '{220, 200, 150, 120, 100, 80};
  int def_dly [NP] = '{10, 40, 70, 100, 130, 160};
  int shape_tbl [16] = '{2, 5, 14, 35, 71, 124, 185, 235, 255, 235, 185, 124, 71, 35, 14, 5};

  always_comb begin
    amp_i   = '0;
    delay_i = '0;
    for (int k = 0; k < NP; k++) begin
      amp_i[8*k +: 8]           = amp[k][7:0];
      delay_i[CNT_W*k +: CNT_W] = dly[k][CNT_W-1:0];
    end
  end

  echo_train_gen #(.N_ECHO(NP-1), .DW(DW), .CNT_W(CNT_W), .PERIOD(PERIOD), .NOISE_W(NOISE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .noise_en(noise_en),
    .amp_i(amp_i), .delay_i(delay_i), .sum_o(sum_o), .start_o(start_o), .busy(busy),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; int st; int frame; int busy; } exp_t;
  exp_t q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame running flag, frame position, latched config, noise register.
  bit m_run;
  int m_cnt, m_lfsr;
  int m_amp [NP];
  int m_dly [NP];

  function automatic int pulse(input int k, input int c);
    if (c >= m_dly[k] && c <= m_dly[k] + 15) return (m_amp[k] * shape_tbl[c - m_dly[k]]) / 256;
    return 0;
  endfunction

  function automatic int lfsr_next(input int l);
    int b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  initial begin : model
    exp_t e;
    int s;
    forever begin
      @(posedge clk or posedge reset);
      e.sum = 0; e.st = 0; e.frame = 0; e.busy = 0;
      if (reset) begin
        m_run = 0; m_cnt = 0; m_lfsr = 16'hACE1;
        for (int k = 0; k < NP; k++) begin m_amp[k] = 0; m_dly[k] = 0; end
        q.delete();
        q.push_back(e);
      end else begin
        if (m_run && !stop) begin
          s = 0;
          for (int k = 0; k < NP; k++) s += pulse(k, m_cnt);
          if (noise_en) s += m_lfsr & ((1 << NOISE_W) - 1);
          e.sum   = (s > SMAX) ? SMAX : s;
          e.st    = pulse(0, m_cnt);
          e.frame = (m_cnt == PERIOD - 1) ? 1 : 0;
        end
        if (m_run) m_lfsr = lfsr_next(m_lfsr);
        if (stop) begin
          m_run = 0; m_cnt = 0;
        end else if (!m_run) begin
          if (start) begin
            m_run = 1; m_cnt = 0; m_amp = amp; m_dly = dly;
          end
        end else if (m_cnt == PERIOD - 1) begin
          m_cnt = 0;
          if (mode) begin m_amp = amp; m_dly = dly; end
          else m_run = 0;
        end else begin
          m_cnt++;
        end
        e.busy = m_run ? 1 : 0;
        q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sum_o", int'(sum_o), e.sum);
        check("start_o", int'(start_o), e.st);
        check("frame_o", int'(frame_o), e.frame);
        check("busy", int'(busy), e.busy);
      end
    end
  end

  // Leaves the bench #1 after edge t0, the edge that samples start.
  task automatic launch();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    for (int k = 0; k < NP; k++) begin amp[k] = 0; dly[k] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset sum_o", int'(sum_o), 0);
    check("reset start_o", int'(start_o), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_o", int'(frame_o), 0);
    reset = 1'b0;

    // single pulse, single shot
    amp[0] = 255; dly[0] = 10;
    launch();
    cycles(11);  check("single cnt10", int'(sum_o), 1);
    cycles(8);   check("single peak", int'(sum_o), 254);
    check("single start_o peak", int'(start_o), 254);
    cycles(181); check("single frame_o", int'(frame_o), 1);
    check("single busy drop", int'(busy), 0);
    cycles(1);   check("single frame_o once", int'(frame_o), 0);

    // default six-pulse train
    amp = def_amp; dly = def_dly;
    launch();
    cycles(49);  check("train peak cnt48", int'(sum_o), 199);
    cycles(160);

    // saturation
    for (int k = 0; k < NP; k++) begin amp[k] = 255; dly[k] = 10; end
    launch();
    cycles(19);  check("saturate cnt18", int'(sum_o), SMAX);
    cycles(190);

    // continuous mode, mid-frame config change, ignored start, then stop
    amp = def_amp; dly = def_dly; mode = 1'b1;
    launch();
    cycles(31);
    dly[0] = 50; start = 1'b1;
    cycles(1);   start = 1'b0;
    cycles(227); check("cont next-frame peak cnt58", int'(sum_o), 219);
    cycles(242); stop = 1'b1;
    cycles(1);   stop = 1'b0;
    check("stop busy", int'(busy), 0);
    check("stop sum_o", int'(sum_o), 0);
    start = 1'b1; stop = 1'b1;
    cycles(3);   check("start+stop stays idle", int'(busy), 0);
    start = 1'b0; stop = 1'b0; mode = 1'b0;

    // noise only, with idle gaps where the LFSR must hold
    for (int k = 0; k < NP; k++) amp[k] = 0;
    noise_en = 1'b1;
    launch();
    cycles(PERIOD + 7);
    launch();
    cycles(PERIOD / 2);
    stop = 1'b1; cycles(1); stop = 1'b0;
    cycles(5);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NP; k++) begin
        amp[k] = $urandom_range(255, 0); dly[k] = $urandom_range(PERIOD - 1, 0);
      end
      mode = 1'($urandom_range(1, 0)); noise_en = 1'($urandom_range(1, 0));
      for (int c = 0; c < 260; c++) begin
        start = ($urandom_range(19, 0) == 0);
        stop  = ($urandom_range(399, 0) == 0);
        if ($urandom_range(49, 0) == 0) begin
          amp[$urandom_range(NP - 1, 0)] = $urandom_range(255, 0);
          dly[$urandom_range(NP - 1, 0)] = $urandom_range(PERIOD - 1, 0);
        end
        if ($urandom_range(29, 0) == 0) noise_en = ~noise_en;
        if ($urandom_range(99, 0) == 0) mode = ~mode;
        cycles(1);
      end
      start = 1'b0; stop = 1'b1; cycles(1); stop = 1'b0;
    end
    mode = 1'b0;

    // asynchronous reset mid-frame, relaunch from seed
    amp = def_amp; dly = def_dly; noise_en = 1'b1;
    launch();
    cycles(101);
    #1 reset = 1'b1;
    #1;
    check("async rst sum_o", int'(sum_o), 0);
    check("async rst start_o", int'(start_o), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst frame_o", int'(frame_o), 0);
    cycles(2);
    reset = 1'b0;
    launch();
    cycles(1);   check("relaunch seed noise", int'(sum_o), 16'hACE1 & ((1 << NOISE_W) - 1));
    cycles(PERIOD + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/echo_train_gen.md
# echo_train_gen

Synthesisable multi-echo rangefinder stimulus generator: produces a start pulse plus up to N_ECHO Gaussian-shaped echo pulses per frame, each with runtime amplitude and delay, summed with optional LFSR noise into one saturating sample stream. It replaces per-pulse generator instances plus external summing and random noise. It can run single-shot or free-running, so the same block drives both simulation benches and on-board loopback tests of the time-of-flight detector.

## Interface
- N_ECHO, 5, number of echo pulses (1..8); pulse 0 is the start pulse, so N_ECHO+1 pulses in total
- DW, 10, output sample width (9..16)
- CNT_W, 16, frame counter and delay width
- PERIOD, 200, frame length in clocks (must be ≥ 2)
- NOISE_W, 4, noise bits added (0 disables noise hardware)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch frame (sampled in IDLE only)
- stop  in  1  abort to IDLE (priority over start)
- mode  in  1  0 = single frame, 1 = continuous
- noise_en  in  1  add noise to sum_o
- amp_i  in  8*(N_ECHO+1)  packed amplitudes, pulse k at [8k+7:8k]
- delay_i  in  CNT_W*(N_ECHO+1)  packed delays, pulse k at [CNT_W*k+CNT_W-1:CNT_W*k]
- sum_o  out  DW  summed, saturated sample
- start_o  out  8  pulse 0 shape alone, no noise
- busy  out  1  high in RUN
- frame_o  out  1  one-cycle strobe at each frame end

## Operation
- States: IDLE, RUN.
- IDLE → RUN: start=1 and stop=0. The frame counter cnt becomes 0. amp_i and delay_i are latched into internal registers.
- RUN: cnt increments by 1 each cycle.
- At cnt = PERIOD-1, frame_o=1 for that cycle. Then:
  - mode=1: cnt wraps to 0, amp_i/delay_i are re-latched, state stays RUN.
  - mode=0: state returns to IDLE.
- stop=1 in any state: next state is IDLE, cnt is cleared, and no frame_o is issued.
- start while in RUN is ignored.
- Shape table, 16 entries, index 0..15: 2,5,14,35,71,124,185,235,255,235,185,124,71,35,14,5.
- Pulse k is active when delay_k ≤ cnt ≤ delay_k+15 (comparison in CNT_W+1 bits, no wrap).
  - When active, its value is (amp_k × shape[cnt−delay_k]) >> 8, giving 8 bits, maximum 254.
  - When inactive, its value is 0.
- Pulses extending past PERIOD-1 are truncated. Delays ≥ PERIOD never appear.
- Overlapping pulses add.
- Noise: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - Advances once per RUN cycle; holds in IDLE.
  - Noise term = lfsr[NOISE_W-1:0] when noise_en=1, else 0.
- Sum = all pulses + noise, computed at full width, then saturated to 2^DW−1.
- start_o carries pulse 0's value only.
- In IDLE, sum_o and start_o are driven to 0 on the next edge.

## Timing
- Reset values: sum_o=0, start_o=0, busy=0, frame_o=0, state=IDLE, cnt=0, lfsr=16'hACE1, latched config=0.
- Latency: start sampled at edge t0 gives busy=1 after t0.
- sum_o and start_o are registered. The value after edge t0+1+c corresponds to cnt=c.
- frame_o is registered, aligned with the sum_o sample for cnt=PERIOD-1.
- In continuous mode there is no gap: the sample for cnt=0 of the next frame follows immediately.
- Asynchronous reset mid-frame: all outputs clear immediately, with no partial frame_o.
- stop and start in the same cycle while in IDLE: the block stays in IDLE.
- mode is sampled only at cnt=PERIOD-1.
- Config changes mid-frame have no effect until the next frame latch.

## Test plan
- Single pulse, amp0=255, delay0=10, other amplitudes 0, noise_en=0, mode=0, start at t0:
  - sum_o=0 through the cnt=9 sample.
  - Samples for cnt=10..25 are 1,4,13,34,70,123,184,234,254,234,184,123,70,34,13,4.
  - start_o is identical.
  - frame_o appears after t0+PERIOD; busy drops after t0+PERIOD.
- Default six-pulse train (amps 220,200,150,120,100,80; delays 10,40,70,100,130,160; noise off):
  - Peaks are 219,199,149,119,99,79 at cnt=18,48,78,108,138,168.
  - start_o is 0 outside cnt 10..25.
- Saturation, DW=9: all amplitudes 255, all delays 10. The cnt=18 sample is 511, clamped from 1524 (6 × 254).
- Continuous mode, PERIOD=200: frame_o every 200 cycles.
  - delay0 changed to 50 mid-frame: the current frame keeps its peak at cnt=18; the next frame peaks at cnt=58.
  - stop mid-frame: IDLE next cycle, sum_o=0, no frame_o.
- Noise, NOISE_W=4, all amplitudes 0, noise_en=1: sum_o equals the low 4 bits of the LFSR sequence from 16'hACE1, advancing only in RUN.
- Asynchronous reset asserted at cnt=100: all outputs 0 immediately. After release, start relaunches from cnt=0 with the LFSR at the seed.
